fan_tach_monitor: RTL
=====================

// Module: fan_tach_monitor
// PURPOSE
//   Reader side of the fan interface: measures the six open-collector tach lines (i_fan_speed)
//   that return from the fans driven by o_fan_pwm. Per fan: synchronise, deglitch, count falling
//   edges over a fixed gate window, publish per-window counts and stall flags to PS/fan control.
//   Sits in the PL between board pins and the SoC register/GPIO side, in the i_sys_aclk domain.
// PARAMETERS
//   NUM_FANS       6            number of tach inputs
//   CLK_HZ         100_000_000  i_sys_aclk frequency
//   WINDOW_MS      1000         gate window length, ms (window cycles = CLK_HZ/1000*WINDOW_MS)
//   SYNC_STAGES    2            synchroniser flops per input (>=2)
//   FILTER_LEN     8            cycles a synced level must stay stable before it is accepted (>=1)
//   CNT_W          16           width of each per-fan count
//   STALL_WINDOWS  3            consecutive zero-count windows that declare a stall (>=1)
// PORTS
//   i_sys_aclk    in   1               system clock
//   i_sys_rst_n   in   1               synchronous active-low reset
//   i_enable      in   1               1 = measure; 0 = timer/live counters held cleared
//   i_fan_speed   in   NUM_FANS        raw async tach inputs (idle high, pulled up)
//   o_fan_cnt     out  NUM_FANS*CNT_W  last completed window counts, fan n at [n*CNT_W +: CNT_W]
//   o_valid       out  1               1-cycle pulse: o_fan_cnt/o_stall updated this cycle
//   o_stall       out  NUM_FANS        per-fan stall flag
//   o_irq         out  1               only with FAN_TACH_IRQ_EN (see CONFIGURATION)
//   i_irq_clr     in   1               only with FAN_TACH_IRQ_EN
// BEHAVIOUR
//   - Clocking/reset: one clock (i_sys_aclk); reset synchronous active-low (i_sys_rst_n), all
//     state cleared on the first rising edge with i_sys_rst_n=0. Reset values: o_fan_cnt=0,
//     o_valid=0, o_stall=0, o_irq=0; sync and filter flops reset to 1 (idle) -> no false edge.
//   - Synchroniser: SYNC_STAGES flops per input, no other logic before the last stage.
//   - Filter: per-fan run counter; filtered level takes the synced value only after FILTER_LEN
//     consecutive identical cycles differing from the current filtered level. Pulses shorter
//     than FILTER_LEN cycles are discarded.
//   - Edge: falling edge of filtered level = 1-cycle strobe. Pin-to-strobe latency
//     = SYNC_STAGES + FILTER_LEN + 1 cycles.
//   - Live counter: +1 per strobe, saturates at 2**CNT_W-1 (no wrap).
//   - Window timer: counts 0..WIN-1 while i_enable=1; at WIN-1 (terminal): o_fan_cnt <= live
//     counts, o_valid=1 next cycle, live counters restart. Strobe on the terminal cycle is
//     counted into the NEW window (new live value = 1), never lost, never double-counted.
//   - Stall: per-fan zero-window counter (saturating at STALL_WINDOWS). At terminal: count==0 ->
//     increment; o_stall set when it reaches STALL_WINDOWS. Non-zero count -> counter cleared,
//     o_stall cleared in the same update. o_stall changes only with o_valid.
//   - i_enable=0: timer and live counters held at 0, no o_valid; o_fan_cnt/o_stall hold last
//     values; sync/filter keep running. Re-enable starts a full fresh window.
//   - Reset mid-window: partial counts discarded; first o_valid is WIN cycles after enable seen.
// CONFIGURATION
//   FAN_TACH_IRQ_EN defined: o_irq and i_irq_clr exist; o_irq sticky, set the cycle any o_stall
//     bit rises 0->1, cleared by i_irq_clr=1; set wins over simultaneous clear.
//   Not defined: ports absent, no irq logic; all other behaviour identical.
// STRUCTURE
//   Package fan_tach_pkg: default constants (CLK_HZ, WINDOW_MS, CNT_W), function for window
//   cycle count and $clog2 timer width, typedef for per-fan count.
//   Sub-module fan_tach_chan: sync + filter + edge strobe + saturating live counter + stall
//   counter for one fan; instantiated NUM_FANS times via generate. Window timer, output
//   latching and irq stay in fan_tach_monitor.
// TESTING (bench params: CLK_HZ=100_000, WINDOW_MS=1 -> WIN=100, FILTER_LEN=4, STALL_WINDOWS=3)
//   1 Reset, i_enable=1, inputs high -> outputs 0 during reset; first o_valid exactly 100 cycles
//     after enable sampled, counts 0.
//   2 Fan0 square wave period 20 cycles (10L/10H) -> o_fan_cnt[0]=5 every window, other fans 0.
//   3 Fan1 2-cycle low glitches every 10 cycles -> o_fan_cnt[1]=0; falling edge on terminal cycle
//     -> appears in next window's count.
//   4 Fan3 held high -> o_stall[3]=1 with 3rd o_valid; resume toggling -> clears at first
//     non-zero window; with FAN_TACH_IRQ_EN o_irq=1 until i_irq_clr.
//   5 CNT_W=2, 5 edges in one window -> o_fan_cnt[0]=3 (saturated).
//   6 Drop i_enable / assert reset at cycle 50 -> no o_valid, partial count discarded; next
//     window after re-enable reports only new edges.

Source files
------------

// File: rtl/fan_tach_pkg.sv
// Shared defaults and window-sizing helpers for the fan tach monitor.
package fan_tach_pkg;

    localparam int unsigned DEF_CLK_HZ    = 100_000_000;
    localparam int unsigned DEF_WINDOW_MS = 1000;
    localparam int unsigned DEF_CNT_W     = 16;

    typedef logic [DEF_CNT_W-1:0] fan_cnt_t;

    function automatic int unsigned win_cycles(input int unsigned clk_hz,
                                               input int unsigned window_ms);
        return (clk_hz / 1000) * window_ms;
    endfunction

    function automatic int unsigned timer_w(input int unsigned win);
        return (win > 1) ? $clog2(win) : 1;
    endfunction

endpackage

// File: rtl/fan_tach_chan.sv
// One tach channel: synchroniser, run-length deglitch filter, falling-edge strobe,
// saturating live counter and zero-window counter driving stall set/clear requests.
module fan_tach_chan
    import fan_tach_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_LEN    = 8,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned STALL_WINDOWS = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_terminal,
    input  logic             i_tach,
    output logic [CNT_W-1:0] o_live_cnt,
    output logic             o_stall_set,
    output logic             o_stall_clr
);

    localparam int unsigned RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned ZC_W  = $clog2(STALL_WINDOWS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [RUN_W-1:0]       r_run;
    logic                   r_filt;
    logic                   r_strobe;
    logic [CNT_W-1:0]       r_live;
    logic [ZC_W-1:0]        r_zc;
    logic                   w_sync;
    logic                   w_accept;
    logic                   w_zero;
    logic                   w_reach;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_accept = (w_sync != r_filt) && (r_run == RUN_W'(FILTER_LEN - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync   <= '1;
            r_run    <= '0;
            r_filt   <= 1'b1;
            r_strobe <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_tach};
            r_strobe <= w_accept & ~w_sync;
            if (w_sync == r_filt) begin
                r_run <= '0;
            end else if (w_accept) begin
                r_run  <= '0;
                r_filt <= w_sync;
            end else begin
                r_run <= r_run + RUN_W'(1);
            end
        end
    end

    // A strobe on the terminal cycle seeds the new window instead of the closing one.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_enable) begin
            r_live <= '0;
        end else if (i_terminal) begin
            r_live <= CNT_W'(r_strobe);
        end else if (r_strobe && (r_live != CNT_MAX)) begin
            r_live <= r_live + CNT_W'(1);
        end
    end

    assign o_live_cnt = r_live;

    assign w_zero  = (r_live == '0);
    assign w_reach = (r_zc >= ZC_W'(STALL_WINDOWS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_zc <= '0;
        end else if (i_terminal) begin
            if (!w_zero) begin
                r_zc <= '0;
            end else if (r_zc != ZC_W'(STALL_WINDOWS)) begin
                r_zc <= r_zc + ZC_W'(1);
            end
        end
    end

    // The stall flag itself lives in the top so the irq logic can see its 0->1 edge.
    assign o_stall_set = i_terminal && w_zero && w_reach;
    assign o_stall_clr = i_terminal && !w_zero;

endmodule

// File: rtl/fan_tach_monitor.sv
// Fan tach monitor: per-fan edge counts over a fixed gate window plus stall flags.
// Define FAN_TACH_IRQ_EN to add the sticky stall interrupt (o_irq / i_irq_clr).
module fan_tach_monitor
    import fan_tach_pkg::*;
#(
    parameter int unsigned NUM_FANS      = 6,
    parameter int unsigned CLK_HZ        = DEF_CLK_HZ,
    parameter int unsigned WINDOW_MS     = DEF_WINDOW_MS,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_LEN    = 8,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned STALL_WINDOWS = 3
) (
    input  logic                      i_sys_aclk,
    input  logic                      i_sys_rst_n,
    input  logic                      i_enable,
    input  logic [NUM_FANS-1:0]       i_fan_speed,
    output logic [NUM_FANS*CNT_W-1:0] o_fan_cnt,
    output logic                      o_valid,
    output logic [NUM_FANS-1:0]       o_stall
`ifdef FAN_TACH_IRQ_EN
    ,
    output logic                      o_irq,
    input  logic                      i_irq_clr
`endif
);

    localparam int unsigned WIN   = win_cycles(CLK_HZ, WINDOW_MS);
    localparam int unsigned TMR_W = timer_w(WIN);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN - 1);

    logic [TMR_W-1:0]          r_timer;
    logic [NUM_FANS*CNT_W-1:0] r_fan_cnt;
    logic                      r_valid;
    logic [NUM_FANS-1:0]       r_stall;
    logic                      w_terminal;
    logic [CNT_W-1:0]          w_live [NUM_FANS];
    logic [NUM_FANS-1:0]       w_stall_set;
    logic [NUM_FANS-1:0]       w_stall_clr;

    assign w_terminal = i_enable && (r_timer == TMR_LAST);

    always_ff @(posedge i_sys_aclk) begin
        if (!i_sys_rst_n || !i_enable || w_terminal) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_FANS; g++) begin : g_chan
        fan_tach_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_LEN    (FILTER_LEN),
            .CNT_W         (CNT_W),
            .STALL_WINDOWS (STALL_WINDOWS)
        ) u_chan (
            .i_clk       (i_sys_aclk),
            .i_rst_n     (i_sys_rst_n),
            .i_enable    (i_enable),
            .i_terminal  (w_terminal),
            .i_tach      (i_fan_speed[g]),
            .o_live_cnt  (w_live[g]),
            .o_stall_set (w_stall_set[g]),
            .o_stall_clr (w_stall_clr[g])
        );
    end

    always_ff @(posedge i_sys_aclk) begin
        if (!i_sys_rst_n) begin
            r_fan_cnt <= '0;
            r_valid   <= 1'b0;
            r_stall   <= '0;
        end else begin
            r_valid <= w_terminal;
            for (int unsigned n = 0; n < NUM_FANS; n++) begin
                if (w_terminal) begin
                    r_fan_cnt[n*CNT_W +: CNT_W] <= w_live[n];
                end
                if (w_stall_set[n]) begin
                    r_stall[n] <= 1'b1;
                end else if (w_stall_clr[n]) begin
                    r_stall[n] <= 1'b0;
                end
            end
        end
    end

    assign o_fan_cnt = r_fan_cnt;
    assign o_valid   = r_valid;
    assign o_stall   = r_stall;

`ifdef FAN_TACH_IRQ_EN
    logic r_irq;

    always_ff @(posedge i_sys_aclk) begin
        if (!i_sys_rst_n) begin
            r_irq <= 1'b0;
        end else if (|(w_stall_set & ~r_stall)) begin
            r_irq <= 1'b1;
        end else if (i_irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign o_irq = r_irq;
`endif

endmodule
